// File: rtl/router_fifo_if.sv
// Port bundle for one router output buffer: write/read handshake, flush and status flags.
// The FIFO connects through the slave modport. The driving logic (synchroniser and reader) connects through master.
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );

    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );
endinterface

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router. It holds header-tagged bytes and clears the output once a packet has drained.
// Optional build macro ROUTER_FIFO_TRISTATE_EN: the cases that clear data_out drive high-Z instead of zero.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic          clock,
    input  logic          resetn,
    router_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'bz}};
`else
    localparam logic [WIDTH-1:0] CLR_VAL = '0;
`endif

    typedef struct packed {
        logic             hdr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [6:0]    count;
    logic          full_c, empty_c;
    logic          do_wr, do_rd;
    entry_t        rd_word;

    // Each pointer is an index plus one wrap bit. Equal indices therefore mean full or empty, depending on the wrap bits.
    assign empty_c  = (wr_ptr == rd_ptr);
    assign full_c   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign bus.full  = full_c;
    assign bus.empty = empty_c;

    assign do_wr   = bus.write_enb && !full_c && !bus.soft_reset;
    assign do_rd   = bus.read_enb  && !empty_c && !bus.soft_reset;
    assign rd_word = mem[rd_ptr[AW-1:0]];

    // A soft reset leaves the stored words alone. Only a hard reset scrubs them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= '{hdr: bus.lfd_state, data: bus.data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                // Header byte carries the payload length in [7:2]. The extra one accounts for the parity byte.
                if (rd_word.hdr)
                    count <= 7'(rd_word.data[WIDTH-1:2]) + 7'd1;
                else if (count != '0)
                    count <= count - 7'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            bus.data_out <= CLR_VAL;
        else if (bus.soft_reset)
            bus.data_out <= CLR_VAL;
        else if (do_rd)
            bus.data_out <= rd_word.data;
        else if (count == '0)
            bus.data_out <= CLR_VAL;
    end
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: reset, single packet, fill/overflow, full read+write, soft reset, pointer wrap.
module tb_router_fifo;
`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [7:0] CLR = 8'bz;
`else
    localparam logic [7:0] CLR = 8'h00;
`endif

    logic clock;
    logic resetn;
    int   nvec;
    int   nerr;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock of stimulus. Outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic we, input logic re, input logic lfd, input logic sr, input logic [7:0] d);
        bus.write_enb  = we;
        bus.read_enb   = re;
        bus.lfd_state  = lfd;
        bus.soft_reset = sr;
        bus.data_in    = d;
        @(posedge clock);
        #1;
    endtask

    logic [7:0] pkt_d [5];
    logic [6:0] pkt_c [5];

    initial begin
        nvec = 0;
        nerr = 0;
        pkt_d = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h5A};
        pkt_c = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
        resetn = 1'b0;
        bus.write_enb = 0; bus.read_enb = 0; bus.lfd_state = 0;
        bus.soft_reset = 0; bus.data_in = 8'h00;
        #12;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_dout",  32'(bus.data_out), 32'(CLR));
        resetn = 1'b1;

        // A read straight out of reset finds nothing.
        cyc(0, 1, 0, 0, 8'h00);
        chk("rst_rd_empty", 32'(bus.empty), 32'd1);
        chk("rst_rd_dout",  32'(bus.data_out), 32'(CLR));

        // Single packet: header 0x0C gives a length field of 3, so count is loaded with 4.
        cyc(1, 0, 1, 0, 8'h0C);
        chk("pkt_empty_deassert", 32'(bus.empty), 32'd0);
        cyc(1, 0, 0, 0, 8'h11);
        cyc(1, 0, 0, 0, 8'h22);
        cyc(1, 0, 0, 0, 8'h33);
        cyc(1, 0, 0, 0, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 8'h00);
            chk($sformatf("pkt_dout%0d", i), 32'(bus.data_out), 32'(pkt_d[i]));
            chk($sformatf("pkt_cnt%0d", i),  32'(dut.count), 32'(pkt_c[i]));
        end
        chk("pkt_drained", 32'(bus.empty), 32'd1);
        cyc(0, 0, 0, 0, 8'h00);
        chk("pkt_idle_clr", 32'(bus.data_out), 32'(CLR));

        // Fill to 16, then try a 17th write, which must be dropped.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 0, 8'(i * 7 + 1));
            if (i == 14) chk("fill_not_full15", 32'(bus.full), 32'd0);
        end
        chk("fill_full16", 32'(bus.full), 32'd1);
        cyc(1, 0, 0, 0, 8'hEE);
        chk("fill_full17", 32'(bus.full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 0, 8'h00);
            chk($sformatf("fill_rd%0d", i), 32'(bus.data_out), 32'(8'(i * 7 + 1)));
            if (i == 0) chk("fill_full_deassert", 32'(bus.full), 32'd0);
        end
        chk("fill_empty", 32'(bus.empty), 32'd1);

        // Full plus simultaneous read and write: the read proceeds and the write is dropped.
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(8'h80 + i));
        chk("rw_full_pre", 32'(bus.full), 32'd1);
        cyc(1, 1, 0, 0, 8'h99);
        chk("rw_full_post", 32'(bus.full), 32'd0);
        chk("rw_dout",      32'(bus.data_out), 32'h80);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 1, 0, 0, 8'h00);
            chk($sformatf("rw_rd%0d", i), 32'(bus.data_out), 32'(8'(8'h80 + i)));
        end
        chk("rw_occ15_empty", 32'(bus.empty), 32'd1);

        // Soft reset mid-packet, issued together with a read.
        cyc(1, 0, 1, 0, 8'h0C);
        cyc(1, 0, 0, 0, 8'h11);
        cyc(1, 0, 0, 0, 8'h22);
        cyc(1, 0, 0, 0, 8'h33);
        cyc(1, 0, 0, 0, 8'h5A);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("sr_pre_dout", 32'(bus.data_out), 32'h11);
        chk("sr_pre_cnt",  32'(dut.count), 32'd3);
        cyc(0, 1, 0, 1, 8'h00);
        chk("sr_empty", 32'(bus.empty), 32'd1);
        chk("sr_cnt",   32'(dut.count), 32'd0);
        chk("sr_dout",  32'(bus.data_out), 32'(CLR));
        cyc(0, 1, 0, 0, 8'h00);
        chk("sr_rd_ignored", 32'(bus.data_out), 32'(CLR));

        // Wrap: hold occupancy at 1 for 40 write/read pairs.
        cyc(1, 0, 0, 0, 8'h40);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 0, 8'(8'h41 + i));
            chk($sformatf("wrap_rd%0d", i), 32'(bus.data_out), 32'(8'(8'h40 + i)));
            chk($sformatf("wrap_full%0d", i), 32'(bus.full), 32'd0);
        end
        cyc(0, 1, 0, 0, 8'h00);
        chk("wrap_last", 32'(bus.data_out), 32'h68);
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Asynchronous reset asserted mid-simulation, with data in the buffer.
        cyc(1, 0, 0, 0, 8'hA5);
        cyc(0, 1, 0, 0, 8'h00);
        chk("arst_pre_dout", 32'(bus.data_out), 32'hA5);
        cyc(1, 0, 0, 0, 8'h5C);
        chk("arst_pre_empty", 32'(bus.empty), 32'd0);
        bus.write_enb = 0;
        #2 resetn = 1'b0;
        #1;
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_full",  32'(bus.full),  32'd0);
        chk("arst_dout",  32'(bus.data_out), 32'(CLR));
        @(negedge clock);
        resetn = 1'b1;
        cyc(0, 1, 0, 0, 8'h00);
        chk("arst_rd_ignored", 32'(bus.data_out), 32'(CLR));
        chk("arst_rd_empty",   32'(bus.empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
